onchip_mem_stream_reader: RTL and testbench

Avalon-MM read master that fetches a block of consecutive 32-bit words from the single-port on-chip frame memory (fixed 1-cycle read latency, registered address, unregistered data) and emits them as a packetised Avalon-ST stream with ready/valid backpressure. It sits between the on-chip memory slave port and the video/processing pipeline, replacing CPU-driven reads for frame readout. A credit-limited internal FIFO absorbs the fixed read latency, so a stalled sink never loses data.

---
 rtl/onchip_mem_reader_pkg.sv | 12 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/onchip_mem_stream_reader.sv | 143 ++++++++++++++
 tb/tb_onchip_mem_stream_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_reader_pkg.sv
// Shared state encoding and memory timing constants for the on-chip memory stream reader.
package onchip_mem_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;

    localparam int unsigned MEM_READ_LATENCY = 1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; head word is visible on rdata whenever count != 0.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (count_q != (PW+1)'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM block reader feeding a packetised Avalon-ST stream; a credit counter bounds
// reads so the return FIFO can always absorb the fixed memory latency.
module onchip_mem_stream_reader
    import onchip_mem_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int unsigned   CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           len_q, issued_q, next_addr_q, addr_q, pop_cnt_q, ret_idx_q;
    logic [CW-1:0]               credit_q, credit_d;
    logic                        cs_q, done_q, done_d;
    logic [MEM_READ_LATENCY-1:0] ret_pend_q, ret_pend_d;
    logic [DATA_W+1:0]           fifo_rdata, fifo_wdata;
    logic [CW-1:0]               fifo_count;
    logic                        start_ok, kill, issue, pop, push, last_pop;

    assign start_ok = (state_q == IDLE) && start && (length != '0);
    assign kill     = abort && (state_q != IDLE);
    assign issue    = (state_q == RUN) && (issued_q != len_q) && (credit_q < CREDIT_MAX) && !abort;
    assign st_valid = (fifo_count != '0);
    assign pop      = st_valid && st_ready;
    assign push     = ret_pend_q[MEM_READ_LATENCY-1];
    assign last_pop = pop && (pop_cnt_q == len_q - ADDR_W'(1));
    assign done_d   = (state_q == DRAIN) && last_pop && !abort;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (kill) state_d = IDLE;
                     else if (issued_q == len_q) state_d = DRAIN;
            DRAIN:   if (kill || last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credit counts reads from the issue decision until their pop; a same-cycle pop
    // only frees credit for the following cycle.
    always_comb begin
        credit_d = credit_q + CW'(issue) - CW'(pop);
        if (start_ok) credit_d = CW'(1);
        if (kill)     credit_d = '0;
    end

    // Returns still in flight at abort are dropped here rather than reaching the FIFO.
    always_comb begin
        ret_pend_d    = ret_pend_q << 1;
        ret_pend_d[0] = cs_q;
        if (kill) ret_pend_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            ret_pend_q  <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            issued_q    <= '0;
            pop_cnt_q   <= '0;
            ret_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            done_q     <= done_d;
            cs_q       <= start_ok || issue;
            ret_pend_q <= ret_pend_d;
            if (start_ok) begin
                len_q       <= length;
                addr_q      <= base_addr;
                next_addr_q <= base_addr + ADDR_W'(1);
                issued_q    <= ADDR_W'(1);
                pop_cnt_q   <= '0;
                ret_idx_q   <= '0;
            end else begin
                if (issue) begin
                    addr_q      <= next_addr_q;
                    next_addr_q <= next_addr_q + ADDR_W'(1);
                    issued_q    <= issued_q + ADDR_W'(1);
                end
                if (pop)  pop_cnt_q <= pop_cnt_q + ADDR_W'(1);
                if (push) ret_idx_q <= ret_idx_q + ADDR_W'(1);
            end
        end
    end

    assign fifo_wdata = {(ret_idx_q == '0), (ret_idx_q == len_q - ADDR_W'(1)), mem_readdata};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (kill),
        .push    (push),
        .wdata   (fifo_wdata),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count)
    );

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign st_data        = st_valid ? fifo_rdata[DATA_W-1:0] : '0;
    assign st_sop         = st_valid && fifo_rdata[DATA_W+1];
    assign st_eop         = st_valid && fifo_rdata[DATA_W];

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader: per-cycle logs checked against hand-derived timing.
module tb_onchip_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, st_ready;
    logic [19:0] base_addr, length;
    logic        busy, done, mem_chipselect, mem_write, mem_clken;
    logic [19:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata, st_data;
    logic        st_valid, st_sop, st_eop;
    logic [7:0]  epoch;

    always #5 clk = ~clk;

    onchip_mem_stream_reader #(
        .ADDR_W     (20),
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop)
    );

    function automatic logic [31:0] mem_word(input logic [7:0] ep, input logic [19:0] a);
        return {4'hD, ep, a};
    endfunction

    // Memory registers the address; data appears the cycle after.
    always @(posedge clk) mem_readdata <= mem_word(epoch, mem_address);

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc, cs_total, pop_total, max_out, done_cnt;
    logic        lg_cs [128], lg_valid [128], lg_sop [128], lg_eop [128];
    logic        lg_done [128], lg_busy [128], lg_ready [128];
    logic [19:0] lg_addr [128];
    logic [31:0] lg_data [128];
    int          lg_popidx [128];
    logic [31:0] pq_data [$];
    logic        pq_sop [$], pq_eop [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_test();
        cyc = 0; cs_total = 0; pop_total = 0; max_out = 0; done_cnt = 0;
        pq_data.delete(); pq_sop.delete(); pq_eop.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        if (cyc < 128) begin
            lg_cs[cyc] = mem_chipselect; lg_addr[cyc] = mem_address; lg_valid[cyc] = st_valid;
            lg_data[cyc] = st_data; lg_sop[cyc] = st_sop; lg_eop[cyc] = st_eop;
            lg_done[cyc] = done; lg_busy[cyc] = busy; lg_ready[cyc] = st_ready;
            lg_popidx[cyc] = pop_total;
        end
        cs_total += int'(mem_chipselect);
        if (cs_total - pop_total > max_out) max_out = cs_total - pop_total;
        if (st_valid && st_ready) begin
            pq_data.push_back(st_data); pq_sop.push_back(st_sop); pq_eop.push_back(st_eop);
            pop_total++;
        end
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " addr"}, 64'(mem_address), 64'd0);
        chk({tag, " cs"}, 64'(mem_chipselect), 64'd0);
        chk({tag, " write"}, 64'(mem_write), 64'd0);
        chk({tag, " be"}, 64'(mem_byteenable), 64'hF);
        chk({tag, " clken"}, 64'(mem_clken), 64'd1);
        chk({tag, " valid"}, 64'(st_valid), 64'd0);
        chk({tag, " data"}, 64'(st_data), 64'd0);
        chk({tag, " sop"}, 64'(st_sop), 64'd0);
        chk({tag, " eop"}, 64'(st_eop), 64'd0);
    endtask

    task automatic check_packet(input string tag, input logic [7:0] ep, input logic [19:0] base,
                                input int n);
        logic [19:0] a;
        chk({tag, " word count"}, 64'(pq_data.size()), 64'(n));
        for (int i = 0; i < n && i < pq_data.size(); i++) begin
            a = base + 20'(i);
            chk($sformatf("%s data[%0d]", tag, i), 64'(pq_data[i]), 64'(mem_word(ep, a)));
            chk($sformatf("%s sop[%0d]", tag, i), 64'(pq_sop[i]), 64'(i == 0));
            chk($sformatf("%s eop[%0d]", tag, i), 64'(pq_eop[i]), 64'(i == n - 1));
        end
    endtask

    task automatic launch(input logic [19:0] b, input logic [19:0] l);
        base_addr = b; length = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [19:0] a;
        logic [19:0] wrap_addr [4];
        int          first_cs, last_cs;
        logic        exp_cs, exp_valid;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; st_ready = 1'b0;
        base_addr = '0; length = '0; epoch = 8'd0;
        #12;
        chk_reset("por");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic transfer, sink always ready.
        begin_test(); epoch = 8'd1; st_ready = 1'b1;
        launch(20'h00010, 20'd8);
        repeat (13) tick();
        for (int c = 0; c <= 13; c++) begin
            exp_cs    = (c >= 1 && c <= 8);
            exp_valid = (c >= 3 && c <= 10);
            chk($sformatf("t1 cs c%0d", c), 64'(lg_cs[c]), 64'(exp_cs));
            if (exp_cs) begin
                a = 20'h00010 + 20'(c - 1);
                chk($sformatf("t1 addr c%0d", c), 64'(lg_addr[c]), 64'(a));
            end
            chk($sformatf("t1 valid c%0d", c), 64'(lg_valid[c]), 64'(exp_valid));
            if (exp_valid) begin
                a = 20'h00010 + 20'(c - 3);
                chk($sformatf("t1 data c%0d", c), 64'(lg_data[c]), 64'(mem_word(8'd1, a)));
                chk($sformatf("t1 sop c%0d", c), 64'(lg_sop[c]), 64'(c == 3));
                chk($sformatf("t1 eop c%0d", c), 64'(lg_eop[c]), 64'(c == 10));
            end
            chk($sformatf("t1 done c%0d", c), 64'(lg_done[c]), 64'(c == 11));
            chk($sformatf("t1 busy c%0d", c), 64'(lg_busy[c]), 64'(c >= 1 && c <= 10));
        end

        // Same transfer with ready pattern 1,0,0,1.
        begin_test(); epoch = 8'd2;
        for (int k = 0; k < 40; k++) begin
            st_ready = (k % 4 == 0) || (k % 4 == 3);
            if (k == 0) launch(20'h00010, 20'd8);
            else tick();
        end
        check_packet("t2", 8'd2, 20'h00010, 8);
        chk("t2 done count", 64'(done_cnt), 64'd1);
        chk("t2 read count", 64'(cs_total), 64'd8);
        chk("t2 credit bound", 64'(max_out > 4), 64'd0);
        first_cs = -1; last_cs = -1;
        for (int c = 0; c < 40; c++) begin
            if (lg_cs[c]) begin
                if (first_cs < 0) first_cs = c;
                last_cs = c;
            end
            if (lg_valid[c] && lg_popidx[c] < 8) begin
                a = 20'h00010 + 20'(lg_popidx[c]);
                chk($sformatf("t2 data c%0d", c), 64'(lg_data[c]), 64'(mem_word(8'd2, a)));
                chk($sformatf("t2 sop c%0d", c), 64'(lg_sop[c]), 64'(lg_popidx[c] == 0));
                chk($sformatf("t2 eop c%0d", c), 64'(lg_eop[c]), 64'(lg_popidx[c] == 7));
            end
        end
        chk("t2 issue stalled", 64'(last_cs - first_cs + 1 > 8), 64'd1);

        // Address wrap at the top of the address space.
        begin_test(); epoch = 8'd3; st_ready = 1'b1;
        launch(20'hFFFFE, 20'd4);
        repeat (9) tick();
        wrap_addr[0] = 20'hFFFFE; wrap_addr[1] = 20'hFFFFF;
        wrap_addr[2] = 20'h00000; wrap_addr[3] = 20'h00001;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3 cs c%0d", i + 1), 64'(lg_cs[i + 1]), 64'd1);
            chk($sformatf("t3 addr c%0d", i + 1), 64'(lg_addr[i + 1]), 64'(wrap_addr[i]));
            if (i < pq_data.size())
                chk($sformatf("t3 data[%0d]", i), 64'(pq_data[i]), 64'(mem_word(8'd3, wrap_addr[i])));
        end
        chk("t3 word count", 64'(pq_data.size()), 64'd4);
        chk("t3 done c7", 64'(lg_done[7]), 64'd1);

        // Single-word packet.
        begin_test(); epoch = 8'd4; st_ready = 1'b1;
        launch(20'h00123, 20'd1);
        repeat (5) tick();
        chk("t4 valid c3", 64'(lg_valid[3]), 64'd1);
        chk("t4 sop c3", 64'(lg_sop[3]), 64'd1);
        chk("t4 eop c3", 64'(lg_eop[3]), 64'd1);
        chk("t4 data c3", 64'(lg_data[3]), 64'(mem_word(8'd4, 20'h00123)));
        chk("t4 valid c4", 64'(lg_valid[4]), 64'd0);
        chk("t4 done c4", 64'(lg_done[4]), 64'd1);
        chk("t4 done count", 64'(done_cnt), 64'd1);

        // Zero length is a no-op.
        begin_test();
        launch(20'h00050, 20'd0);
        repeat (5) tick();
        chk("t4z reads", 64'(cs_total), 64'd0);
        chk("t4z done count", 64'(done_cnt), 64'd0);
        for (int c = 0; c <= 5; c++)
            chk($sformatf("t4z busy c%0d", c), 64'(lg_busy[c]), 64'd0);

        // Abort in cycle 4 with a stalled sink, then an immediate new transfer.
        begin_test(); epoch = 8'd5; st_ready = 1'b0;
        launch(20'h00200, 20'd16);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        epoch = 8'd6; st_ready = 1'b1;
        launch(20'h00300, 20'd3);
        repeat (8) tick();
        chk("t5 busy c4", 64'(lg_busy[4]), 64'd1);
        chk("t5 valid c4", 64'(lg_valid[4]), 64'd1);
        chk("t5 busy c5", 64'(lg_busy[5]), 64'd0);
        chk("t5 valid c5", 64'(lg_valid[5]), 64'd0);
        chk("t5 done c5", 64'(lg_done[5]), 64'd0);
        chk("t5 done c11", 64'(lg_done[11]), 64'd1);
        chk("t5 done count", 64'(done_cnt), 64'd1);
        check_packet("t5", 8'd6, 20'h00300, 3);

        // Asynchronous reset mid-RUN, then a clean 2-word packet.
        begin_test(); epoch = 8'd7; st_ready = 1'b1;
        launch(20'h00040, 20'd16);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        tick();
        tick();
        for (int c = 4; c <= 5; c++) begin
            chk($sformatf("t6 busy c%0d", c), 64'(lg_busy[c]), 64'd0);
            chk($sformatf("t6 cs c%0d", c), 64'(lg_cs[c]), 64'd0);
            chk($sformatf("t6 valid c%0d", c), 64'(lg_valid[c]), 64'd0);
            chk($sformatf("t6 data c%0d", c), 64'(lg_data[c]), 64'd0);
        end
        reset_n = 1'b1;
        begin_test(); epoch = 8'd8;
        launch(20'h00080, 20'd2);
        repeat (7) tick();
        check_packet("t6", 8'd8, 20'h00080, 2);
        chk("t6 done c5", 64'(lg_done[5]), 64'd1);
        chk("t6 done count", 64'(done_cnt), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
